// File: rtl/pll_seq_pkg.sv
// PLL lock sequencer shared types.
// State encoding, saturating-counter limit and counter sizing.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        S_RESET_PLL = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } pll_state_t;

    localparam logic [7:0] CNT8_MAX = 8'hFF;

    // Width of a counter able to reach the largest of three cycle limits.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchronizer.
// Reset drives every stage to 0.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/relock sequencer on the reference clock.
// Holds the core in reset until lock has been stable long enough.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE     = 16,
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ready,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int CW = cnt_width(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;

    pll_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pll_rst_q, pll_rst_d;
    logic          core_rst_q, core_rst_d;
    logic          ready_q, ready_d;
    logic [7:0]    retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          retry_inc;
    logic          loss_inc;
    logic          locked_s;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (locked_s)
    );

    // Next state, shared cycle counter, event counters and registered outputs.
    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;

        if (relock_req) begin
            state_d = S_RESET_PLL;
        end else begin
            unique case (state_q)
                S_RESET_PLL: begin
                    if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = S_STABLE;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d   = S_RESET_PLL;
                        retry_inc = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_d  = S_WAIT_LOCK;
                        loss_inc = 1'b1;
                    end
                end
                default: state_d = S_RESET_PLL;
            endcase
        end

        // A relock restarts the pulse even when the state does not change.
        if (relock_req || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        retry_d = retry_q;
        if (retry_inc && (retry_q != CNT8_MAX)) retry_d = retry_q + 8'd1;

        loss_d = loss_q;
        if (loss_inc && (loss_q != CNT8_MAX)) loss_d = loss_q + 8'd1;

        pll_rst_d  = (state_d == S_RESET_PLL);
        core_rst_d = (state_d != S_RUN);
        ready_d    = (state_d == S_RUN);
    end

    // State, counters and output registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= S_RESET_PLL;
            cnt_q      <= '0;
            pll_rst_q  <= 1'b1;
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            retry_q    <= 8'd0;
            loss_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pll_rst_q  <= pll_rst_d;
            core_rst_q <= core_rst_d;
            ready_q    <= ready_d;
            retry_q    <= retry_d;
            loss_q     <= loss_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign core_rst  = core_rst_q;
    assign ready     = ready_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer: PLL model, timestamp-based
// reference model, bring-up table, corner sequences and random traffic.
module tb_pll_lock_sequencer;

    localparam int RP = 4;
    localparam int LT = 64;
    localparam int SC = 16;
    localparam int SS = 2;

    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STAB = 2;
    localparam int PH_RUN  = 3;

    typedef struct {
        int fails;
        int n;
        int exp_retry;
        int exp_pulses;
    } vec_t;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       core_rst;
    logic       ready;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    pll_lock_sequencer #(
        .RST_PULSE     (RP),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .SYNC_STAGES   (SS)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .core_rst   (core_rst),
        .ready      (ready),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #5 refclk = ~refclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model: phase plus the cycle it was entered
    int m_phase = PH_RST;
    int m_enter = 0;
    int m_retry = 0;
    int m_loss = 0;
    bit lq[$];

    // PLL environment model
    int pm_n = 10;
    int pm_fail = 0;
    int pm_since = -1;
    bit pm_dead = 1'b0;
    bit pm_lock = 1'b0;
    int force_low = 0;

    // event trackers
    int last_rise = 0;
    int last_fall = 0;
    int rise_cnt = 0;
    int ready_rise = 0;
    int core_rise = 0;
    bit prev_pl = 1'b0;
    bit prev_ready = 1'b0;
    bit prev_core = 1'b1;
    int hi_run = 0;
    int lo_run = 0;
    int pulses[$];
    int gaps[$];

    vec_t tbl[3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit rq, input bit pl);
        bit ls;
        int e;
        ls = lq[0];
        void'(lq.pop_front());
        lq.push_back(pl);
        e = cyc - m_enter - 1;
        if (r) begin
            m_phase = PH_RST;
            m_enter = cyc;
            m_retry = 0;
            m_loss  = 0;
            lq.delete();
            repeat (SS) lq.push_back(1'b0);
        end else if (rq) begin
            m_phase = PH_RST;
            m_enter = cyc;
        end else begin
            case (m_phase)
                PH_RST: begin
                    if (e == RP - 1) begin
                        m_phase = PH_WAIT;
                        m_enter = cyc;
                    end
                end
                PH_WAIT: begin
                    if (ls) begin
                        m_phase = PH_STAB;
                        m_enter = cyc;
                    end else if (e == LT - 1) begin
                        m_phase = PH_RST;
                        m_enter = cyc;
                        m_retry++;
                    end
                end
                PH_STAB: begin
                    if (!ls) begin
                        m_phase = PH_WAIT;
                        m_enter = cyc;
                    end else if (e == SC - 1) begin
                        m_phase = PH_RUN;
                        m_enter = cyc;
                    end
                end
                default: begin
                    if (!ls) begin
                        m_phase = PH_WAIT;
                        m_enter = cyc;
                        m_loss++;
                    end
                end
            endcase
        end
    endtask

    task automatic step();
        logic [18:0] act;
        logic [18:0] exp;
        int mr;
        int ml;
        @(posedge refclk);
        cyc++;
        model_edge(rst, relock_req, pll_locked);
        if (!rst && pll_locked && !prev_pl) begin
            last_rise = cyc;
            rise_cnt++;
        end
        if (!pll_locked && prev_pl) last_fall = cyc;
        prev_pl = pll_locked;
        #1;
        mr = (m_retry > 255) ? 255 : m_retry;
        ml = (m_loss > 255) ? 255 : m_loss;
        exp[18]   = (m_phase == PH_RST);
        exp[17]   = (m_phase != PH_RUN);
        exp[16]   = (m_phase == PH_RUN);
        exp[15:8] = mr[7:0];
        exp[7:0]  = ml[7:0];
        act = {pll_rst, core_rst, ready, retry_cnt, loss_cnt};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model cyc %0d: got %h expected %h", cyc, act, exp);
        end
        if (ready && !prev_ready) ready_rise = cyc;
        prev_ready = ready;
        if (core_rst && !prev_core) core_rise = cyc;
        prev_core = core_rst;
        if (rst) begin
            hi_run = 1;
            lo_run = 0;
        end else if (pll_rst) begin
            hi_run++;
            if (lo_run > 0) begin
                gaps.push_back(lo_run);
                lo_run = 0;
            end
        end else begin
            lo_run++;
            if (hi_run > 0) begin
                pulses.push_back(hi_run);
                hi_run = 0;
            end
        end
        relock_req = 1'b0;
        if (pll_rst) begin
            pm_since = -1;
            pm_lock  = 1'b0;
        end else begin
            if (pm_since < 0) begin
                pm_since = 0;
                pm_dead  = (pm_fail > 0);
                if (pm_fail > 0) pm_fail--;
            end else begin
                pm_since++;
            end
            pm_lock = !pm_dead && (pm_since >= pm_n);
        end
        pll_locked = pm_lock && (force_low == 0);
        if (force_low > 0) force_low--;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int k;
        k = 0;
        while (!ready && k < budget) begin
            step();
            k++;
        end
        chk(name, int'(ready), 1);
    endtask

    task automatic wait_rise(input string name, input int budget);
        int k;
        int target;
        k = 0;
        target = rise_cnt + 1;
        while (rise_cnt < target && k < budget) begin
            step();
            k++;
        end
        if (rise_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s: lock rise not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic do_reset(input int fails, input int n);
        pm_fail = fails;
        pm_n = n;
        force_low = 0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        pulses.delete();
        gaps.delete();
    endtask

    initial begin
        int c0;
        int k;

        repeat (SS) lq.push_back(1'b0);
        tbl[0] = '{0, 10, 0, 1};
        tbl[1] = '{2, 10, 2, 3};
        tbl[2] = '{1, 5, 1, 2};

        // reset values
        pm_n = 10;
        repeat (3) step();
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_core_rst", int'(core_rst), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_retry", int'(retry_cnt), 0);
        chk("rst_loss", int'(loss_cnt), 0);

        // bring-up table: normal lock and timeout retries
        for (int i = 0; i < 3; i++) begin
            do_reset(tbl[i].fails, tbl[i].n);
            wait_ready($sformatf("bringup%0d_ready", i), 1000);
            chk($sformatf("bringup%0d_retry", i), int'(retry_cnt), tbl[i].exp_retry);
            chk($sformatf("bringup%0d_loss", i), int'(loss_cnt), 0);
            chk($sformatf("bringup%0d_npulse", i), pulses.size(), tbl[i].exp_pulses);
            foreach (pulses[j]) chk($sformatf("bringup%0d_pulse%0d", i, j), pulses[j], RP);
            chk($sformatf("bringup%0d_ngap", i), gaps.size(), tbl[i].fails);
            foreach (gaps[j]) chk($sformatf("bringup%0d_gap%0d", i, j), gaps[j], LT);
            chk($sformatf("bringup%0d_latency", i), ready_rise - last_rise + 1, SS + SC + 1);
        end

        // settling glitch of 3 cycles while in the stable window
        do_reset(0, 10);
        wait_rise("glitch_first_rise", 200);
        c0 = last_rise;
        repeat (10) step();
        force_low = 3;
        wait_ready("glitch_ready", 200);
        chk("glitch_loss", int'(loss_cnt), 0);
        chk("glitch_ready_edge", ready_rise - c0, 15 + SS + SC);
        chk("glitch_latency", ready_rise - last_rise + 1, SS + SC + 1);

        // lock loss while running
        force_low = 5;
        k = 0;
        while (!core_rst && k < 50) begin
            step();
            k++;
        end
        chk("loss_core_rst", int'(core_rst), 1);
        chk("loss_core_latency", core_rise - last_fall + 1, SS + 1);
        chk("loss_ready_low", int'(ready), 0);
        chk("loss_count", int'(loss_cnt), 1);
        wait_ready("loss_ready", 200);
        chk("loss_relock_latency", ready_rise - last_rise + 1, SS + SC + 1);

        // relock in run, repeated in the next cycle inside the reset pulse
        pulses.delete();
        relock_req = 1'b1;
        step();
        relock_req = 1'b1;
        step();
        k = 0;
        while (pll_rst && k < 50) begin
            step();
            k++;
        end
        chk("relock_npulse", pulses.size(), 1);
        if (pulses.size() > 0) chk("relock_pulse_len", pulses[0], RP + 1);
        chk("relock_retry", int'(retry_cnt), 0);
        chk("relock_loss", int'(loss_cnt), 1);
        wait_ready("relock_ready", 200);

        // saturate the loss counter
        for (int i = 0; i < 300; i++) begin
            force_low = 3;
            k = 0;
            while (ready && k < 20) begin
                step();
                k++;
            end
            wait_ready("sat_ready", 100);
        end
        chk("sat_loss", int'(loss_cnt), 255);

        // reset in the middle of the stable window
        relock_req = 1'b1;
        step();
        wait_rise("midrst_rise", 200);
        repeat (6) step();
        chk("midrst_pre_ready", int'(ready), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_pll_rst", int'(pll_rst), 1);
        chk("midrst_core_rst", int'(core_rst), 1);
        chk("midrst_ready", int'(ready), 0);
        chk("midrst_retry", int'(retry_cnt), 0);
        chk("midrst_loss", int'(loss_cnt), 0);

        // random traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            if (rst) begin
                pm_n = $urandom_range(1, 20);
                pm_fail = $urandom_range(0, 1);
            end
            relock_req = ($urandom_range(0, 249) == 0);
            if (relock_req) pm_fail = $urandom_range(0, 1);
            if (force_low == 0 && $urandom_range(0, 99) == 0) begin
                force_low = $urandom_range(1, 8);
            end
            step();
        end
        rst = 1'b0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
